// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core (priority) and an external requester.
// Latency: grant and memory muxing are combinational; external read data returns one cycle after grant.
// Backpressure: the external port waits on core-busy cycles. With DMEM_ARB_STARVE_EN defined, the core is stalled one cycle to force it through.
module dmem_arbiter #(
   parameter int          ADDR_W       = 32,
   parameter int          DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] CoreAddr,
   input  logic              CoreRead,
   input  logic              CoreWrite,
   input  logic [DATA_W-1:0] CoreWData,
   output logic [DATA_W-1:0] CoreRData,
   output logic              CoreStall,
   input  logic              ExtReq,
   input  logic              ExtWrite,
   input  logic [ADDR_W-1:0] ExtAddr,
   input  logic [DATA_W-1:0] ExtWData,
   output logic              ExtGnt,
   output logic [DATA_W-1:0] ExtRData,
   output logic              ExtValid,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData
);

   logic              core_acc;
   logic              force_st;
   logic              core_own;
   logic              ext_own;
   logic [DATA_W-1:0] ext_rdata_d, ext_rdata_q;
   logic              ext_valid_d, ext_valid_q;

`ifdef DMEM_ARB_STARVE_EN
   typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t     state_d, state_q;
   logic [7:0] cnt_d, cnt_q;

   assign force_st = (state_q == ST_FORCE);
`else
   // Without the starvation guard the limit has no consumer.
   logic [7:0] unused_starve_limit;
   assign unused_starve_limit = 8'(STARVE_LIMIT);
   assign force_st = 1'b0;
`endif

   assign core_acc = CoreRead | CoreWrite;

   // Ownership and memory mux: core wins unless FORCE hands the cycle to the external port.
   always_comb begin
      core_own  = core_acc & ~force_st;
      ext_own   = force_st | (~core_acc & ExtReq);
      MemAddr   = '0;
      MemWData  = '0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      CoreRData = '0;
      if (core_own) begin
         MemAddr   = CoreAddr;
         MemWData  = CoreWData;
         MemRead   = CoreRead;
         MemWrite  = CoreWrite;
         CoreRData = MemRData;
      end else if (ext_own) begin
         MemAddr  = ExtAddr;
         MemWData = ExtWData;
         MemRead  = ~ExtWrite;
         MemWrite = ExtWrite;
      end
      // Reset suppresses every enable so nothing commits while RST is low.
      MemRead   = MemRead  & RST;
      MemWrite  = MemWrite & RST;
      ExtGnt    = ext_own  & RST;
      CoreStall = force_st & RST;
   end

   // External read capture: latch memory data on a granted read, pulse valid next cycle.
   always_comb begin
      ext_valid_d = ExtGnt & ~ExtWrite;
      ext_rdata_d = ext_valid_d ? MemRData : ext_rdata_q;
   end

   assign ExtRData = ext_rdata_q;
   assign ExtValid = ext_valid_q;

`ifdef DMEM_ARB_STARVE_EN
   // Starvation counter and NORMAL/FORCE next-state: count denied cycles, force one grant at the limit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_FORCE) begin
         state_d = ST_NORMAL;
         cnt_d   = '0;
      end else if (core_acc && ExtReq) begin
         cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 8'd1;
         if (cnt_d == LIMIT) begin
            state_d = ST_FORCE;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Arbitration state registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_NORMAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`endif

   // External read data/valid registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         ext_rdata_q <= '0;
         ext_valid_q <= 1'b0;
      end else begin
         ext_rdata_q <= ext_rdata_d;
         ext_valid_q <= ext_valid_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word memory model (byte address bits [5:2]).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit after that.
// Expectations for the starvation guard follow whichever build (DMEM_ARB_STARVE_EN) is compiled.
module tb_dmem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] CoreAddr, CoreWData, CoreRData;
   logic        CoreRead, CoreWrite, CoreStall;
   logic        ExtReq, ExtWrite, ExtGnt, ExtValid;
   logic [31:0] ExtAddr, ExtWData, ExtRData;
   logic [31:0] MemAddr, MemWData, MemRData;
   logic        MemRead, MemWrite;

   logic [31:0] mem [0:15];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
      .CLK(CLK), .RST(RST),
      .CoreAddr(CoreAddr), .CoreRead(CoreRead), .CoreWrite(CoreWrite),
      .CoreWData(CoreWData), .CoreRData(CoreRData), .CoreStall(CoreStall),
      .ExtReq(ExtReq), .ExtWrite(ExtWrite), .ExtAddr(ExtAddr), .ExtWData(ExtWData),
      .ExtGnt(ExtGnt), .ExtRData(ExtRData), .ExtValid(ExtValid),
      .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemWData(MemWData), .MemRData(MemRData)
   );

   assign MemRData = mem[MemAddr[5:2]];

   always @(posedge CLK) begin
      if (MemWrite) mem[MemAddr[5:2]] <= MemWData;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      RST = 1'b0;
      CoreAddr = '0; CoreWData = '0; CoreRead = 1'b0; CoreWrite = 1'b0;
      ExtReq = 1'b1; ExtWrite = 1'b1; ExtAddr = 32'd16; ExtWData = 32'h77;

      // Reset held two cycles with an external write pending.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_gnt",   32'(ExtGnt),    32'd0);
         chk("rst_mwr",   32'(MemWrite),  32'd0);
         chk("rst_valid", 32'(ExtValid),  32'd0);
         chk("rst_rdata", ExtRData,       32'd0);
         chk("rst_stall", 32'(CoreStall), 32'd0);
      end
      chk("rst_mem16", mem[4], 32'd0);

      // Idle-cycle external write of 0x2A to address 16.
      RST = 1'b1; ExtWData = 32'h2A;
      #1;
      chk("idle_wr_gnt",  32'(ExtGnt),   32'd1);
      chk("idle_wr_mwr",  32'(MemWrite), 32'd1);
      chk("idle_wr_addr", MemAddr,       32'd16);
      tick();
      chk("idle_wr_mem",   mem[4],        32'h2A);
      chk("idle_wr_noval", 32'(ExtValid), 32'd0);

      // Back-to-back external read of address 16.
      ExtWrite = 1'b0;
      #1;
      chk("idle_rd_gnt", 32'(ExtGnt),  32'd1);
      chk("idle_rd_mrd", 32'(MemRead), 32'd1);
      tick();
      ExtReq = 1'b0;
      chk("idle_rd_valid", 32'(ExtValid), 32'd1);
      chk("idle_rd_data",  ExtRData,      32'h2A);
      tick();
      chk("idle_rd_pulse", 32'(ExtValid), 32'd0);

      // Core sw 5 to address 0 collides with external write of 9 to address 0.
      CoreWrite = 1'b1; CoreAddr = 32'd0; CoreWData = 32'd5;
      ExtReq = 1'b1; ExtWrite = 1'b1; ExtAddr = 32'd0; ExtWData = 32'd9;
      #1;
      chk("prio_gnt",   32'(ExtGnt),    32'd0);
      chk("prio_wdata", MemWData,       32'd5);
      chk("prio_stall", 32'(CoreStall), 32'd0);
      tick();
      chk("prio_mem_core", mem[0], 32'd5);
      CoreWrite = 1'b0;
      #1;
      chk("prio_ext_gnt", 32'(ExtGnt), 32'd1);
      tick();
      chk("prio_mem_ext", mem[0], 32'd9);
      ExtReq = 1'b0;

      // Core read data path, then zero when the core does not own memory.
      CoreRead = 1'b1; CoreAddr = 32'd16;
      #1;
      chk("core_rdata", CoreRData, 32'h2A);
      tick();
      CoreRead = 1'b0;
      #1;
      chk("core_rdata_idle", CoreRData, 32'd0);
      chk("idle_no_en",      32'({MemRead, MemWrite}), 32'd0);
      tick();

      // Starvation: core reads every cycle while an external read of address 0 (holds 9) waits.
      CoreRead = 1'b1; CoreAddr = 32'd16;
      ExtReq = 1'b1; ExtWrite = 1'b0; ExtAddr = 32'd0;
`ifdef DMEM_ARB_STARVE_EN
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("starve_wait_gnt",   32'(ExtGnt),    32'd0);
         chk("starve_wait_stall", 32'(CoreStall), 32'd0);
         tick();
      end
      #1;
      chk("force_stall", 32'(CoreStall), 32'd1);
      chk("force_gnt",   32'(ExtGnt),    32'd1);
      chk("force_addr",  MemAddr,        32'd0);
      tick();
      ExtReq = 1'b0;
      #1;
      chk("after_force_stall", 32'(CoreStall), 32'd0);
      chk("after_force_valid", 32'(ExtValid),  32'd1);
      chk("after_force_data",  ExtRData,       32'd9);
      tick();
`else
      for (int i = 0; i < 50; i++) begin
         #1;
         chk("noguard_gnt",   32'(ExtGnt),    32'd0);
         chk("noguard_stall", 32'(CoreStall), 32'd0);
         tick();
      end
      CoreRead = 1'b0;
      #1;
      chk("noguard_idle_gnt", 32'(ExtGnt), 32'd1);
      tick();
      ExtReq = 1'b0;
      chk("noguard_valid", 32'(ExtValid), 32'd1);
      chk("noguard_data",  ExtRData,      32'd9);
      tick();
`endif

      // Reset while an external write of 0x55 to address 0 is pending (mid-FORCE when guarded).
      CoreRead = 1'b1; CoreAddr = 32'd16;
      ExtReq = 1'b1; ExtWrite = 1'b1; ExtAddr = 32'd0; ExtWData = 32'h55;
`ifdef DMEM_ARB_STARVE_EN
      for (int i = 0; i < 8; i++) tick();
`else
      CoreRead = 1'b0;
`endif
      RST = 1'b0;
      #1;
      chk("rstmid_gnt", 32'(ExtGnt),   32'd0);
      chk("rstmid_mwr", 32'(MemWrite), 32'd0);
      tick();
      chk("rstmid_mem",   mem[0],         32'd9);
      chk("rstmid_stall", 32'(CoreStall), 32'd0);
      RST = 1'b1; CoreRead = 1'b1;
      #1;
      chk("rstrel_busy_gnt", 32'(ExtGnt),    32'd0);
      chk("rstrel_stall",    32'(CoreStall), 32'd0);
      tick();
      CoreRead = 1'b0;
      #1;
      chk("rstrel_gnt", 32'(ExtGnt),   32'd1);
      chk("rstrel_mwr", 32'(MemWrite), 32'd1);
      tick();
      ExtReq = 1'b0;
      chk("rstrel_mem", mem[0], 32'h55);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
